calc_sequencer: RTL and testbench
=================================

# calc_sequencer

Controller for the keypad calculator. It synchronises and debounces the one-hot row/column keypad inputs and decodes them into key events. It builds decimal operands A and B, issues a single-operation start/done handshake to the arithmetic datapath, and drives the displayed `answer`. It sits between the keypad pins and the ALU inside `main`.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive identical synchronised samples needed before a key is accepted.
- `MAX_DIGITS`, default 9: maximum digits per operand; further digits are ignored, so the value is always < 2^32.
- `clk` in 1: single clock for the whole block.
- `reset` in 1: synchronous, active-high.
- `IO_P4_ROW` in 4: keypad row, one-hot, bit0 = top row; all-zero = no key.
- `IO_P4_COL` in 4: keypad column, one-hot, bit0 = left column.
- `alu_done` in 1: one-cycle pulse, result valid.
- `alu_result` in 32: ALU result, sampled on `alu_done`.
- `alu_err` in 1: divide-by-zero or overflow, sampled on `alu_done`.
- `alu_start` out 1: one-cycle request pulse.
- `alu_a`, `alu_b` out 32: operands, held stable from `alu_start` until `alu_done`.
- `alu_op` out 2: 0 add, 1 sub, 2 mul, 3 div.
- `answer` out 32: display value; registered.
- `err` out 1: high in the ERR state.

## Operation
- Key map, row/col index order:
  - r0: 1 2 3 +
  - r1: 4 5 6 −
  - r2: 7 8 9 ×
  - r3: CLR 0 = ÷
- Valid key: both ROW and COL are one-hot. Any other non-zero pattern is invalid; it restarts debounce and generates no event.
- Key event: the synchronised pattern has been stable for `DEBOUNCE_CYCLES` samples, is valid, and differs from `last_key`.
  - On the event, `last_key` ← pattern.
  - A stable all-zero pattern (also `DEBOUNCE_CYCLES` samples) clears `last_key` to 0.
  - Repeating the same key therefore requires a release. Changing directly to a different key does not.
- States: S_A, S_B, S_EXEC, S_WAIT, S_RES, S_ERR. Reset enters S_A.
- CLR in any state → S_A with A = B = 0, digit counts = 0, op = add.
- S_A:
  - Digit → A = A·10 + d if digits_a < MAX_DIGITS.
  - Operator → latch op, B = 0, → S_B.
  - '=' is ignored.
- S_B:
  - Digit → B accumulates the same way as A.
  - Operator with digits_b = 0 → replaces op.
  - Operator with digits_b > 0 → ignored.
  - '=' with digits_b > 0 → S_EXEC; with digits_b = 0 → ignored.
- S_EXEC:
  - `alu_start` = 1 for exactly one cycle, with `alu_a` = A, `alu_b` = B, `alu_op` = op.
  - → S_WAIT.
- S_WAIT:
  - Key events are dropped; `last_key` still updates.
  - On `alu_done`: if `alu_err` → S_ERR; else A ← `alu_result`, digits_a = MAX_DIGITS, → S_RES.
- S_RES:
  - Digit → A = d, digits_a = 1, → S_A.
  - Operator → chain with A = result, → S_B.
  - '=' is ignored.
- S_ERR: `answer` = 32'hFFFF_FFFF and `err` = 1; only CLR exits.
- `answer` source by state:
  - A in S_A and S_RES.
  - B in S_B once digits_b > 0; A while digits_b = 0.
  - Unchanged in S_EXEC and S_WAIT.
- All arithmetic is unsigned 32-bit; the ALU owns wrap and overflow detection.

## Timing
- Inputs pass a 2-flop synchroniser.
- A pattern applied before edge t0 produces a key event at edge t0 + 1 + DEBOUNCE_CYCLES.
- The state and `answer` update one edge after the key event, so `answer` reflects the key DEBOUNCE_CYCLES + 2 cycles after it is applied (6 with defaults).
- '=' event at edge t → `alu_start` high during cycle t+1 (registered in S_EXEC).
- `alu_done` at edge t → `answer` = result at t+1.
- `alu_done` outside S_WAIT is ignored.
- Reset values: `answer` = 0, `alu_start` = 0, `alu_a` = `alu_b` = 0, `alu_op` = 0, `err` = 0, `last_key` = 0, debounce counter = 0, synchroniser = 0.
- Reset asserted mid-S_WAIT aborts the request. A subsequent stray `alu_done` is ignored.
- A key event and `alu_done` arriving in the same cycle in S_WAIT: `alu_done` wins and the key is dropped.

## Structure
- Package `calc_pkg`:
  - key code enum (D0–D9, ADD, SUB, MUL, DIV, EQ, CLR, NONE);
  - `alu_op_t`;
  - `state_t`;
  - constant `ERR_DISPLAY` = 32'hFFFF_FFFF.
- Sub-module `key_debounce`: synchroniser, stability counter, `last_key`, one-hot validity check and key decode. It outputs `key_valid` (pulse) and `key_code`.
- The top level holds the FSM, operand registers, digit counters and the ALU handshake.

## Test plan
- Reset with ROW = 2, COL = 4 held → no key event, `answer` = 0. After reset deasserts, the '6' key is accepted after 6 cycles.
- Keys '1', '5', '3' presented back-to-back for 10 cycles each, with no release → `answer` goes 1, 15, 153.
- '1','2','+','3','=' with `alu_done` returning 15 two cycles after `alu_start`:
  - exactly one `alu_start` pulse, with `alu_a` = 12, `alu_b` = 3, `alu_op` = 0;
  - `answer` = 15.
- '5' held for 40 cycles, then released, then '5' again → first press gives `answer` = 5, second gives 55; no repeat while held.
- '8','÷','0','=' with `alu_err` = 1 on `alu_done` → `err` = 1 and `answer` = FFFF_FFFF. Digits are ignored; CLR → `answer` = 0, `err` = 0.
- Ten '9' presses → `answer` = 999_999_999 (10th ignored). Then '+','1','=', result 1_000_000_000, then '×' → S_B with A = 1_000_000_000 (chain).

Source files
------------

// File: rtl/calc_pkg.sv
// Shared types for the keypad calculator controller.
// Key codes, ALU opcodes, FSM states and key-map helpers.
package calc_pkg;

  typedef enum logic [4:0] {
    K_D0  = 5'd0,
    K_D1  = 5'd1,
    K_D2  = 5'd2,
    K_D3  = 5'd3,
    K_D4  = 5'd4,
    K_D5  = 5'd5,
    K_D6  = 5'd6,
    K_D7  = 5'd7,
    K_D8  = 5'd8,
    K_D9  = 5'd9,
    K_ADD = 5'd10,
    K_SUB = 5'd11,
    K_MUL = 5'd12,
    K_DIV = 5'd13,
    K_EQ  = 5'd14,
    K_CLR = 5'd15,
    K_NONE = 5'd16
  } key_t;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2,
    OP_DIV = 2'd3
  } alu_op_t;

  typedef enum logic [2:0] {
    S_A,
    S_B,
    S_EXEC,
    S_WAIT,
    S_RES,
    S_ERR
  } state_t;

  localparam logic [31:0] ERR_DISPLAY = 32'hFFFF_FFFF;

  // idx = {row_index, col_index}
  function automatic key_t key_lut(input logic [3:0] idx);
    key_t k;
    unique case (idx)
      4'd0:  k = K_D1;
      4'd1:  k = K_D2;
      4'd2:  k = K_D3;
      4'd3:  k = K_ADD;
      4'd4:  k = K_D4;
      4'd5:  k = K_D5;
      4'd6:  k = K_D6;
      4'd7:  k = K_SUB;
      4'd8:  k = K_D7;
      4'd9:  k = K_D8;
      4'd10: k = K_D9;
      4'd11: k = K_MUL;
      4'd12: k = K_CLR;
      4'd13: k = K_D0;
      4'd14: k = K_EQ;
      4'd15: k = K_DIV;
    endcase
    return k;
  endfunction

  function automatic alu_op_t key_to_op(input key_t k);
    alu_op_t o;
    o = OP_ADD;
    if (k == K_SUB) o = OP_SUB;
    if (k == K_MUL) o = OP_MUL;
    if (k == K_DIV) o = OP_DIV;
    return o;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Keypad front end: 2-flop sync, stability count, key decode.
// Emits a one-cycle key_valid pulse per accepted press.
module key_debounce
  import calc_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row,
  input  logic [3:0] col,
  output logic       key_valid,
  output key_t       key_code
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES);

  logic [7:0]    sync1_q, sync1_d;
  logic [7:0]    sync2_q, sync2_d;
  logic [7:0]    prev_q, prev_d;
  logic [7:0]    last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          kv_q, kv_d;
  key_t          kc_q, kc_d;

  logic [3:0] r, c;
  logic [1:0] ri, ci;
  logic       ok, stable;

  // Sync, count stable samples, and fire on a new valid pattern.
  always_comb begin
    sync1_d = {row, col};
    sync2_d = sync1_q;
    prev_d  = sync2_q;
    last_d  = last_q;
    kv_d    = 1'b0;
    kc_d    = K_NONE;
    r  = sync2_q[7:4];
    c  = sync2_q[3:0];
    ri = {r[3] | r[2], r[3] | r[1]};
    ci = {c[3] | c[2], c[3] | c[1]};
    ok = $onehot(r) && $onehot(c);
    if (sync2_q != 8'd0 && !ok) begin
      cnt_d = '0;
    end else if (sync2_q != prev_q) begin
      cnt_d = CW'(1);
    end else if (cnt_q != CMAX) begin
      cnt_d = cnt_q + CW'(1);
    end else begin
      cnt_d = cnt_q;
    end
    stable = (cnt_d == CMAX);
    if (stable) begin
      if (sync2_q == 8'd0) begin
        last_d = 8'd0;
      end else if (ok && sync2_q != last_q) begin
        kv_d   = 1'b1;
        kc_d   = key_lut({ri, ci});
        last_d = sync2_q;
      end
    end
  end

  // Debounce state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
      last_q  <= '0;
      cnt_q   <= '0;
      kv_q    <= 1'b0;
      kc_q    <= K_NONE;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      kv_q    <= kv_d;
      kc_q    <= kc_d;
    end
  end

  assign key_valid = kv_q;
  assign key_code  = kc_q;

endmodule

// File: rtl/calc_sequencer.sv
// Keypad calculator controller: operand entry FSM,
// ALU start/done handshake and registered display value.
module calc_sequencer
  import calc_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int MAX_DIGITS      = 9
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  IO_P4_ROW,
  input  logic [3:0]  IO_P4_COL,
  input  logic        alu_done,
  input  logic [31:0] alu_result,
  input  logic        alu_err,
  output logic        alu_start,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [1:0]  alu_op,
  output logic [31:0] answer,
  output logic        err
);

  localparam int DW = $clog2(MAX_DIGITS + 1);
  localparam logic [DW-1:0] DMAX = DW'(MAX_DIGITS);

  logic key_valid;
  key_t key_code;

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_kdb (
    .clk      (clk),
    .reset    (reset),
    .row      (IO_P4_ROW),
    .col      (IO_P4_COL),
    .key_valid(key_valid),
    .key_code (key_code)
  );

  state_t        state_q, state_d;
  logic [31:0]   a_q, a_d, b_q, b_d;
  logic [DW-1:0] da_q, da_d, db_q, db_d;
  alu_op_t       op_q, op_d;
  logic          start_q, start_d;
  logic [31:0]   alu_a_q, alu_a_d;
  logic [31:0]   alu_b_q, alu_b_d;
  alu_op_t       alu_op_q, alu_op_d;
  logic [31:0]   answer_q, answer_d;

  logic        is_dig, is_op, is_eq, is_clr;
  logic [31:0] dval;

  assign is_dig = key_valid && (key_code <= K_D9);
  assign is_op  = key_valid && (key_code inside {K_ADD, K_SUB, K_MUL, K_DIV});
  assign is_eq  = key_valid && (key_code == K_EQ);
  assign is_clr = key_valid && (key_code == K_CLR);
  assign dval   = {28'd0, key_code[3:0]};

  // Next state, operand entry, ALU request and display source.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    da_d     = da_q;
    db_d     = db_q;
    op_d     = op_q;
    start_d  = 1'b0;
    alu_a_d  = alu_a_q;
    alu_b_d  = alu_b_q;
    alu_op_d = alu_op_q;
    if (is_clr && !(state_q == S_WAIT && alu_done)) begin
      state_d = S_A;
      a_d     = '0;
      b_d     = '0;
      da_d    = '0;
      db_d    = '0;
      op_d    = OP_ADD;
    end else begin
      unique case (state_q)
        S_A: begin
          if (is_dig && da_q < DMAX) begin
            a_d  = a_q * 32'd10 + dval;
            da_d = da_q + DW'(1);
          end else if (is_op) begin
            op_d    = key_to_op(key_code);
            b_d     = '0;
            db_d    = '0;
            state_d = S_B;
          end
        end
        S_B: begin
          if (is_dig && db_q < DMAX) begin
            b_d  = b_q * 32'd10 + dval;
            db_d = db_q + DW'(1);
          end else if (is_op && db_q == '0) begin
            op_d = key_to_op(key_code);
          end else if (is_eq && db_q != '0) begin
            start_d  = 1'b1;
            alu_a_d  = a_q;
            alu_b_d  = b_q;
            alu_op_d = op_q;
            state_d  = S_EXEC;
          end
        end
        S_EXEC: state_d = S_WAIT;
        S_WAIT: begin
          if (alu_done) begin
            if (alu_err) begin
              state_d = S_ERR;
            end else begin
              a_d     = alu_result;
              da_d    = DMAX;
              state_d = S_RES;
            end
          end
        end
        S_RES: begin
          if (is_dig) begin
            a_d     = dval;
            da_d    = DW'(1);
            state_d = S_A;
          end else if (is_op) begin
            op_d    = key_to_op(key_code);
            b_d     = '0;
            db_d    = '0;
            state_d = S_B;
          end
        end
        S_ERR: state_d = S_ERR;
        default: state_d = S_A;
      endcase
    end
    unique case (state_d)
      S_A, S_RES: answer_d = a_d;
      S_B:        answer_d = (db_d != '0) ? b_d : a_d;
      S_ERR:      answer_d = ERR_DISPLAY;
      default:    answer_d = answer_q;
    endcase
  end

  // Controller registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_A;
      a_q      <= '0;
      b_q      <= '0;
      da_q     <= '0;
      db_q     <= '0;
      op_q     <= OP_ADD;
      start_q  <= 1'b0;
      alu_a_q  <= '0;
      alu_b_q  <= '0;
      alu_op_q <= OP_ADD;
      answer_q <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      da_q     <= da_d;
      db_q     <= db_d;
      op_q     <= op_d;
      start_q  <= start_d;
      alu_a_q  <= alu_a_d;
      alu_b_q  <= alu_b_d;
      alu_op_q <= alu_op_d;
      answer_q <= answer_d;
    end
  end

  assign alu_start = start_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_op    = alu_op_q;
  assign answer    = answer_q;
  assign err       = (state_q == S_ERR);

endmodule

// File: tb/tb_calc_sequencer.sv
// Scoreboard bench for calc_sequencer: directed key sequences,
// expected display/ALU requests queued, monitors compare.
module tb_calc_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  row = 4'd0;
  logic [3:0]  col = 4'd0;
  logic        alu_done = 1'b0;
  logic [31:0] alu_result = 32'd0;
  logic        alu_err = 1'b0;
  logic        alu_start;
  logic [31:0] alu_a, alu_b;
  logic [1:0]  alu_op;
  logic [31:0] answer;
  logic        err;

  calc_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .IO_P4_ROW (row),
    .IO_P4_COL (col),
    .alu_done  (alu_done),
    .alu_result(alu_result),
    .alu_err   (alu_err),
    .alu_start (alu_start),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_op    (alu_op),
    .answer    (answer),
    .err       (err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        e;
    logic [31:0] v;
  } disp_t;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  op;
  } req_t;

  disp_t exp_q[$];
  req_t  req_q[$];
  disp_t rsp_q[$];
  int    checks = 0;
  int    fails = 0;
  int    n_start = 0;
  bit    stray_req = 1'b0;
  disp_t prev_disp = '0;

  task automatic chk(input string n, input logic [95:0] act,
                     input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  task automatic key(input byte ch, input int hold, input int rel);
    string m;
    int idx;
    m = "123+456-789*C0=/";
    idx = 0;
    for (int i = 0; i < 16; i++)
      if (m[i] == ch) idx = i;
    @(negedge clk);
    row = 4'(1 << (idx / 4));
    col = 4'(1 << (idx % 4));
    repeat (hold) @(negedge clk);
    row = 4'd0;
    col = 4'd0;
    repeat (rel) @(negedge clk);
  endtask

  task automatic k(input byte ch);
    key(ch, 10, 8);
  endtask

  task automatic push_d(input logic e, input logic [31:0] v);
    disp_t d;
    d.e = e;
    d.v = v;
    exp_q.push_back(d);
  endtask

  task automatic push_req(input logic [31:0] a, input logic [31:0] b,
                          input logic [1:0] op, input logic re,
                          input logic [31:0] res);
    req_t r;
    disp_t d;
    r.a = a;
    r.b = b;
    r.op = op;
    d.e = re;
    d.v = res;
    req_q.push_back(r);
    rsp_q.push_back(d);
  endtask

  // Display and ALU-request monitor.
  always @(negedge clk) begin
    disp_t cur;
    req_t  got;
    cur = {err, answer};
    if (!reset && cur !== prev_disp) begin
      if (exp_q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL display_unexpected: got %0h expected no change",
                 cur);
      end else begin
        chk("display", 96'(cur), 96'(exp_q.pop_front()));
      end
    end
    prev_disp = cur;
    if (!reset && alu_start) begin
      n_start++;
      got = {alu_a, alu_b, alu_op};
      if (req_q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL alu_req_unexpected: got %0h expected none", got);
      end else begin
        chk("alu_req", 96'(got), 96'(req_q.pop_front()));
      end
    end
  end

  // ALU model: done two cycles after start; also stray pulses.
  initial begin
    disp_t r;
    bit sp;
    sp = 1'b0;
    forever begin
      @(negedge clk);
      if (alu_start && !reset) begin
        @(negedge clk);
        r = (rsp_q.size() != 0) ? rsp_q.pop_front() : '0;
        alu_result = r.v;
        alu_err = r.e;
        alu_done = 1'b1;
        @(negedge clk);
        alu_done = 1'b0;
      end else if (stray_req && !sp) begin
        alu_result = 32'd77;
        alu_err = 1'b0;
        alu_done = 1'b1;
        @(negedge clk);
        alu_done = 1'b0;
      end
      sp = stray_req;
    end
  end

  initial begin
    logic [31:0] v;
    int n;
    row = 4'd2;
    col = 4'd4;
    repeat (5) @(negedge clk);
    chk("rst_answer", 96'(answer), 96'd0);
    chk("rst_start", 96'(alu_start), 96'd0);
    chk("rst_alu_a", 96'(alu_a), 96'd0);
    chk("rst_alu_b", 96'(alu_b), 96'd0);
    chk("rst_alu_op", 96'(alu_op), 96'd0);
    chk("rst_err", 96'(err), 96'd0);
    push_d(1'b0, 32'd6);
    reset = 1'b0;
    repeat (6) @(negedge clk);
    chk("key6_not_early", 96'(answer), 96'd0);
    @(negedge clk);
    chk("key6_latency", 96'(answer), 96'd6);

    push_d(1'b0, 32'd0);
    key("C", 10, 0);
    push_d(1'b0, 32'd1);
    key("1", 10, 0);
    push_d(1'b0, 32'd15);
    key("5", 10, 0);
    push_d(1'b0, 32'd153);
    key("3", 10, 8);

    push_d(1'b0, 32'd0);
    k("C");
    push_d(1'b0, 32'd1);
    k("1");
    push_d(1'b0, 32'd12);
    k("2");
    k("+");
    push_d(1'b0, 32'd3);
    k("3");
    push_req(32'd12, 32'd3, 2'd0, 1'b0, 32'd15);
    push_d(1'b0, 32'd15);
    k("=");

    push_d(1'b0, 32'd0);
    k("C");
    push_d(1'b0, 32'd5);
    key("5", 40, 8);
    push_d(1'b0, 32'd55);
    k("5");

    push_d(1'b0, 32'd0);
    k("C");
    push_d(1'b0, 32'd8);
    k("8");
    k("/");
    push_d(1'b0, 32'd0);
    k("0");
    push_req(32'd8, 32'd0, 2'd3, 1'b1, 32'd0);
    push_d(1'b1, 32'hFFFF_FFFF);
    k("=");
    k("7");
    chk("err_hold", 96'({err, answer}), 96'({1'b1, 32'hFFFF_FFFF}));
    push_d(1'b0, 32'd0);
    k("C");
    stray_req = 1'b1;
    repeat (6) @(negedge clk);
    stray_req = 1'b0;
    chk("stray_done_idle", 96'(answer), 96'd0);

    v = 32'd0;
    for (int i = 0; i < 9; i++) begin
      v = v * 32'd10 + 32'd9;
      push_d(1'b0, v);
      k("9");
    end
    k("9");
    chk("max_digits", 96'(answer), 96'd999_999_999);
    k("+");
    push_d(1'b0, 32'd1);
    k("1");
    push_req(32'd999_999_999, 32'd1, 2'd0, 1'b0, 32'd1_000_000_000);
    push_d(1'b0, 32'd1_000_000_000);
    k("=");
    k("*");
    push_d(1'b0, 32'd2);
    k("2");
    push_req(32'd1_000_000_000, 32'd2, 2'd2, 1'b0, 32'd2_000_000_000);
    push_d(1'b0, 32'd2_000_000_000);
    k("=");

    k("+");
    push_d(1'b0, 32'd1);
    k("1");
    push_req(32'd2_000_000_000, 32'd1, 2'd0, 1'b0, 32'd5);
    @(negedge clk);
    row = 4'd8;
    col = 4'd4;
    n = 0;
    while (!alu_start && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("wait_start_seen", 96'(alu_start), 96'd1);
    @(negedge clk);
    reset = 1'b1;
    row = 4'd0;
    col = 4'd0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (8) @(negedge clk);
    stray_req = 1'b1;
    repeat (6) @(negedge clk);
    stray_req = 1'b0;
    chk("abort_answer", 96'(answer), 96'd0);
    chk("abort_err", 96'(err), 96'd0);

    repeat (20) @(negedge clk);
    chk("exp_q_empty", 96'(exp_q.size()), 96'd0);
    chk("req_q_empty", 96'(req_q.size()), 96'd0);
    chk("rsp_q_empty", 96'(rsp_q.size()), 96'd0);
    chk("start_count", 96'(n_start), 96'd5);
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
